// File: rtl/aes_block_loader.sv
// Byte-serial loader/unloader that frames key and plaintext for an iterative AES-128 core.
// Defining AES_LOADER_KEY_REUSE_EN adds s_newkey so a frame may reuse the stored key.
module aes_block_loader #(
    parameter int unsigned CORE_LATENCY = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
`ifdef AES_LOADER_KEY_REUSE_EN
    input  logic         s_newkey,
`endif
    output logic [127:0] core_key,
    output logic [127:0] core_data,
    output logic         core_reset,
    input  logic [127:0] core_cipher,
    output logic [7:0]   m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    typedef enum logic [1:0] {StLoadKey, StLoadData, StRun, StUnload} state_e;

    localparam logic [7:0] RunLast = 8'(CORE_LATENCY - 1);

    state_e       r_state;
    state_e       w_state_next;
    logic [127:0] r_key;
    logic [127:0] r_data;
    logic [127:0] r_shift;
    logic [3:0]   r_byte_cnt;
    logic [7:0]   r_run_cnt;
    logic         w_s_fire;
    logic         w_m_fire;
    logic         w_key_byte;
    logic         w_byte_last;
    logic         w_run_done;

    assign w_s_fire    = s_valid & s_ready;
    assign w_m_fire    = m_valid & m_ready;
    assign w_byte_last = (r_byte_cnt == 4'd15);
    assign w_run_done  = (r_run_cnt == RunLast);

`ifdef AES_LOADER_KEY_REUSE_EN
    // Only the first byte of a frame can divert straight to plaintext.
    assign w_key_byte = (r_byte_cnt != 4'd0) | s_newkey;
`else
    assign w_key_byte = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StLoadKey;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoadKey: begin
                if (w_s_fire && (!w_key_byte || w_byte_last)) begin
                    w_state_next = StLoadData;
                end
            end
            StLoadData: begin
                if (w_s_fire && w_byte_last) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_run_done) begin
                    w_state_next = StUnload;
                end
            end
            StUnload: begin
                if (w_m_fire && w_byte_last) begin
                    w_state_next = StLoadKey;
                end
            end
            default: w_state_next = StLoadKey;
        endcase
    end

    always_comb begin
        s_ready    = (r_state == StLoadKey) || (r_state == StLoadData);
        m_valid    = (r_state == StUnload);
        core_reset = (r_state != StRun);
        m_data     = r_shift[127:120];
        core_key   = r_key;
        core_data  = r_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key      <= '0;
            r_data     <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_run_cnt  <= '0;
        end else begin
            unique case (r_state)
                StLoadKey: begin
                    if (w_s_fire) begin
                        if (w_key_byte) begin
                            r_key <= {r_key[119:0], s_data};
                        end else begin
                            r_data <= {r_data[119:0], s_data};
                        end
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                StLoadData: begin
                    if (w_s_fire) begin
                        r_data     <= {r_data[119:0], s_data};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                StRun: begin
                    if (w_run_done) begin
                        r_shift   <= core_cipher;
                        r_run_cnt <= '0;
                    end else begin
                        r_run_cnt <= r_run_cnt + 8'd1;
                    end
                end
                StUnload: begin
                    // Zero fill leaves m_data back at 0 once the frame drains.
                    if (w_m_fire) begin
                        r_shift    <= {r_shift[119:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a cycle-accurate stand-in for the AES core.
// Key-reuse frames are exercised when AES_LOADER_KEY_REUSE_EN is defined.
module tb_aes_block_loader;

    localparam int unsigned  Lat   = 11;
    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] AltK  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] AltP  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] Junk  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_newkey;
    logic [127:0] core_key;
    logic [127:0] core_data;
    logic         core_reset;
    logic [127:0] core_cipher;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          core_cnt = 0;
    int          t_last;
    logic [127:0] got;

    aes_block_loader #(.CORE_LATENCY(Lat)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
`ifdef AES_LOADER_KEY_REUSE_EN
        .s_newkey    (s_newkey),
`endif
        .core_key    (core_key),
        .core_data   (core_data),
        .core_reset  (core_reset),
        .core_cipher (core_cipher),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: result is only presented on the exact cycle the loader must capture it.
    always @(posedge clk) core_cnt <= core_reset ? 0 : core_cnt + 1;

    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
        if (k == C1Key && p == C1Pt) return C1Ct;
        return k ^ p ^ 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    endfunction

    assign core_cipher = (core_cnt == int'(Lat) - 1) ? core_model(core_key, core_data) : Junk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [127:0] key, input logic [127:0] pt, input bit with_key,
                              input bit gaps, input bit newkey, input int n_max,
                              output int t_end);
        int n;
        int j;
        int budget;
        logic [127:0] w;
        n = with_key ? 32 : 16;
        if (n_max < n) n = n_max;
        t_end = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
            @(negedge clk);
            w = (with_key && i < 16) ? key : pt;
            j = (with_key && i >= 16) ? i - 16 : i;
            s_data = w[127 - 8*j -: 8];
`ifdef AES_LOADER_KEY_REUSE_EN
            s_newkey = (i == 0) ? newkey : ~newkey;
`else
            s_newkey = newkey;
`endif
            s_valid = 1'b1;
            budget = 0;
            while (!s_ready && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            if (!s_ready) check_eq("s_ready_timeout", 128'(s_ready), 128'd1);
            t_end = cyc;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic recv_frame(input int t_end, input bit stall, input int limit,
                              output logic [127:0] data);
        int k;
        int nrx;
        int budget;
        logic [7:0] prev;
        bit prev_stall;
        k = 0;
        nrx = 0;
        budget = 0;
        prev = 8'h00;
        prev_stall = 1'b0;
        data = '0;
        m_ready = 1'b0;
        while (!m_valid && budget < 300) begin
            check_eq("core_reset_run", 128'(core_reset),
                     (cyc >= t_end + 1 && cyc <= t_end + int'(Lat)) ? 128'd0 : 128'd1);
            check_eq("s_ready_run", 128'(s_ready), 128'd0);
            @(negedge clk);
            budget++;
        end
        check_eq("first_byte_cycle", 128'(cyc), 128'(t_end + int'(Lat) + 1));
        while (nrx < limit && budget < 600) begin
            m_ready = stall ? (k >= 5 && (k - 5) % 3 == 0) : 1'b1;
            check_eq("m_valid_unload", 128'(m_valid), 128'd1);
            if (prev_stall) check_eq("m_data_hold", 128'(m_data), 128'(prev));
            if (stall && nrx == 0 && !m_ready) check_eq("m_data_stall", 128'(m_data), 128'h69);
            if (m_valid && m_ready) begin
                data = {data[119:0], m_data};
                nrx++;
            end
            prev = m_data;
            prev_stall = m_valid && !m_ready;
            if (nrx < limit) begin
                @(negedge clk);
                k++;
                budget++;
            end
        end
        if (nrx < limit) check_eq("rx_count", 128'(nrx), 128'(limit));
        if (limit == 16) begin
            @(negedge clk);
            m_ready = 1'b0;
            check_eq("s_ready_after", 128'(s_ready), 128'd1);
            check_eq("m_valid_after", 128'(m_valid), 128'd0);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_s_ready"}, 128'(s_ready), 128'd1);
        check_eq({tag, "_m_valid"}, 128'(m_valid), 128'd0);
        check_eq({tag, "_m_data"}, 128'(m_data), 128'd0);
        check_eq({tag, "_core_reset"}, 128'(core_reset), 128'd1);
        check_eq({tag, "_core_key"}, core_key, 128'd0);
        check_eq({tag, "_core_data"}, core_data, 128'd0);
    endtask

    task automatic full_frame(input string tag, input logic [127:0] key, input logic [127:0] pt,
                              input bit gaps, input bit stall);
        send_frame(key, pt, 1'b1, gaps, 1'b1, 32, t_last);
        check_eq({tag, "_key"}, core_key, key);
        check_eq({tag, "_data"}, core_data, pt);
        recv_frame(t_last, stall, 16, got);
        check_eq({tag, "_cipher"}, got, core_model(key, pt));
    endtask

    initial begin
        reset = 1'b1;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_newkey = 1'b0;
        m_ready = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;

        full_frame("c1", C1Key, C1Pt, 1'b0, 1'b0);
        full_frame("gaps", C1Key, C1Pt, 1'b1, 1'b0);
        full_frame("stall", C1Key, C1Pt, 1'b0, 1'b1);
        full_frame("alt", AltK, AltP, 1'b0, 1'b0);

        // Abort a frame 20 bytes in, then load a clean one.
        send_frame(C1Key, C1Pt, 1'b1, 1'b0, 1'b1, 20, t_last);
        #2 reset = 1'b1;
        #1 check_idle("rst_load");
        @(negedge clk);
        reset = 1'b0;
        full_frame("after_rst_load", C1Key, C1Pt, 1'b0, 1'b0);

        // Abort during unload after four bytes have left.
        send_frame(C1Key, C1Pt, 1'b1, 1'b0, 1'b1, 32, t_last);
        recv_frame(t_last, 1'b0, 4, got);
        check_eq("rst_unload_first4", got, {96'd0, C1Ct[127:96]});
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_idle("rst_unload");
        @(negedge clk);
        reset = 1'b0;
        m_ready = 1'b0;
        full_frame("after_rst_unload", C1Key, C1Pt, 1'b0, 1'b0);

`ifdef AES_LOADER_KEY_REUSE_EN
        full_frame("reuse_first", C1Key, C1Pt, 1'b0, 1'b0);
        send_frame(AltK, C1Pt, 1'b0, 1'b0, 1'b0, 16, t_last);
        check_eq("reuse_key", core_key, C1Key);
        check_eq("reuse_data", core_data, C1Pt);
        recv_frame(t_last, 1'b0, 16, got);
        check_eq("reuse_cipher", got, C1Ct);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
